// File: rtl/sif_pkg.sv
// Shared helpers for the SIF (valid/ready stream) buffer family.
// Contents:
//   sif_hs_t   - one valid/ready handshake pair
//   sif_ptr_w  - pointer width for a power-of-two RAM depth (address + wrap bit)
//   sif_lvl_w  - occupancy-level width for a buffer holding depth+2 entries
package sif_pkg;

    typedef struct packed {
        logic vld;
        logic rdy;
    } sif_hs_t;

    function automatic int unsigned sif_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Level runs 0..depth+2 (RAM + read in flight + 2-entry prefetch).
    function automatic int unsigned sif_lvl_w(input int unsigned depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/sif_sdp_ram.sv
// Simple dual-port RAM, W x D, one write port and one registered read port.
// The array has no reset so synthesis can map it onto block/ultra RAM.
// Ports:
//   clk   - clock
//   we    - write enable;  waddr / wdata - write address / data
//   re    - read enable;   raddr         - read address
//   rdata - read data, valid the cycle after re
module sif_sdp_ram #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 1024
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(D)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic                 re,
    input  logic [$clog2(D)-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sif_fifo_lvl.sv
// Valid/ready FIFO with occupancy level, almost-full/almost-empty flags and
// synchronous flush. Storage is a D-entry RAM (1-cycle read) followed by a
// 2-entry prefetch queue whose head drives dn_dat, giving D+2 entries total.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous clear of all contents
//   up_vld/up_dat/up_rdy  - upstream (push) side
//   dn_vld/dn_dat/dn_rdy  - downstream (pop) side, dn_dat registered
//   level                 - entries held, 0..D+2
//   almost_full           - registered level >= AF_TH
//   almost_empty          - registered level <= AE_TH
module sif_fifo_lvl
    import sif_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned D     = 1024,
    parameter int unsigned AF_TH = D,
    parameter int unsigned AE_TH = 1,
    localparam int unsigned LW   = sif_lvl_w(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          up_vld,
    input  logic [W-1:0]  up_dat,
    output logic          up_rdy,
    output logic          dn_vld,
    output logic [W-1:0]  dn_dat,
    input  logic          dn_rdy,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int unsigned AW = $clog2(D);
    localparam int unsigned PW = sif_ptr_w(D);
    localparam logic [LW-1:0] AfTh = LW'(AF_TH);
    localparam logic [LW-1:0] AeTh = LW'(AE_TH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          rd_pend_q;
    logic [1:0]    pf_cnt_q, pf_cnt_d;
    logic [W-1:0]  pf_q [2];
    logic [W-1:0]  pf_d [2];
    logic [LW-1:0] level_q, level_d;
    logic          af_q, ae_q;

    logic          ram_empty, ram_full;
    logic          push, pop, rd_issue;
    logic [2:0]    pf_committed;
    logic [W-1:0]  ram_rdata;
    sif_hs_t       up_hs, dn_hs;

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // up_rdy looks only at registered state and flush: no dn_rdy path.
    assign up_rdy = ~ram_full & ~flush;
    assign dn_vld = (pf_cnt_q != 2'd0);
    assign dn_dat = pf_q[0];

    assign up_hs = '{vld: up_vld, rdy: up_rdy};
    assign dn_hs = '{vld: dn_vld, rdy: dn_rdy};
    assign push  = up_hs.vld & up_hs.rdy;
    assign pop   = dn_hs.vld & dn_hs.rdy & ~flush;

    // Prefetch slots spoken for after this edge, counting the read in flight.
    // pop implies pf_cnt_q >= 1, so this never underflows.
    assign pf_committed = {1'b0, pf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_issue     = ~ram_empty & ~flush & (pf_committed < 3'd2);

    sif_sdp_ram #(
        .W (W),
        .D (D)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (up_dat),
        .re    (rd_issue),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Prefetch queue: shift on pop, then land the returning RAM word in the
    // first free slot. The issue rule guarantees a free slot exists.
    always_comb begin
        pf_d     = pf_q;
        pf_cnt_d = pf_cnt_q;
        if (pop) begin
            pf_d[0]  = pf_q[1];
            pf_cnt_d = pf_cnt_q - 2'd1;
        end
        if (rd_pend_q) begin
            if (pf_cnt_d == 2'd0) begin
                pf_d[0] = ram_rdata;
            end else begin
                pf_d[1] = ram_rdata;
            end
            pf_cnt_d = pf_cnt_d + 2'd1;
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            pf_cnt_q  <= 2'd0;
            pf_q[0]   <= '0;
            pf_q[1]   <= '0;
            level_q   <= '0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            level_q <= level_d;
            af_q    <= (level_d >= AfTh);
            ae_q    <= (level_d <= AeTh);
            pf_q    <= pf_d;
            if (flush) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                rd_pend_q <= 1'b0;
                pf_cnt_q  <= 2'd0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (rd_issue) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                rd_pend_q <= rd_issue;
                pf_cnt_q  <= pf_cnt_d;
            end
        end
    end

    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_sif_fifo_lvl.sv
// Bench for sif_fifo_lvl (W=32, D=8, AF_TH=8, AE_TH=1). A negedge monitor
// keeps a scoreboard queue of accepted words and an expected level; the main
// thread drives directed sequences and checks cycle-exact behaviour.
module tb_sif_fifo_lvl;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          up_vld = 1'b0;
    logic [W-1:0]  up_dat = '0;
    logic          up_rdy;
    logic          dn_vld;
    logic [W-1:0]  dn_dat;
    logic          dn_rdy = 1'b0;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          almost_empty;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] sb [$];
    int           exp_level = 0;
    logic         stall_q = 1'b0;
    logic [W-1:0] held_dat = '0;

    sif_fifo_lvl #(
        .W     (W),
        .D     (D),
        .AF_TH (8),
        .AE_TH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .up_vld       (up_vld),
        .up_dat       (up_dat),
        .up_rdy       (up_rdy),
        .dn_vld       (dn_vld),
        .dn_dat       (dn_dat),
        .dn_rdy       (dn_rdy),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: sampled mid-cycle, so inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_level = 0;
            stall_q   = 1'b0;
        end else begin
            chk("level", 64'(level), 64'(exp_level));
            chk("almost_full", 64'(almost_full), 64'(exp_level >= 8));
            chk("almost_empty", 64'(almost_empty), 64'(exp_level <= 1));
            if (stall_q) begin
                chk("dn_vld_hold", 64'(dn_vld), 64'd1);
                chk("dn_dat_hold", 64'(dn_dat), 64'(held_dat));
            end
            if (flush) begin
                sb.delete();
                exp_level = 0;
                stall_q   = 1'b0;
            end else begin
                if (up_vld && up_rdy) begin
                    sb.push_back(up_dat);
                    exp_level++;
                end
                if (dn_vld && dn_rdy) begin
                    if (sb.size() == 0) chk("pop_with_empty_sb", 64'(dn_vld), 64'd0);
                    else chk("sb_data", 64'(dn_dat), 64'(sb.pop_front()));
                    exp_level--;
                end
                stall_q  = dn_vld && !dn_rdy;
                held_dat = dn_dat;
            end
        end
    end

    // Offer words base, base+1, ... until n are accepted or the budget runs out.
    task automatic push_words(input int n, input logic [W-1:0] base, input int budget,
                              output int got);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(posedge clk); #1;
            up_vld = 1'b1;
            up_dat = base + W'(got);
            @(negedge clk);
            if (up_rdy) got++;
        end
        @(posedge clk); #1;
        up_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        dn_rdy = 1'b1;
        for (int c = 0; c < budget && (sb.size() != 0 || dn_vld); c++) @(negedge clk);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int pops;

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_dn_vld", 64'(dn_vld), 64'd0);
        chk("rst_dn_dat", 64'(dn_dat), 64'd0);
        chk("rst_ae", 64'(almost_empty), 64'd1);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_up_rdy", 64'(up_rdy), 64'd1);

        // 1: single word latency
        @(posedge clk); #1;
        up_vld = 1'b1; up_dat = 32'hA0; dn_rdy = 1'b1;
        @(posedge clk); #1;
        up_vld = 1'b0;
        @(negedge clk);
        chk("t1_lvl_e0", 64'(level), 64'd1);
        chk("t1_vld_e0", 64'(dn_vld), 64'd0);
        @(negedge clk);
        chk("t1_vld_e1", 64'(dn_vld), 64'd0);
        @(negedge clk);
        chk("t1_vld_e2", 64'(dn_vld), 64'd1);
        chk("t1_dat_e2", 64'(dn_dat), 64'hA0);
        chk("t1_lvl_e2", 64'(level), 64'd1);
        @(negedge clk);
        chk("t1_lvl_e3", 64'(level), 64'd0);
        chk("t1_vld_e3", 64'(dn_vld), 64'd0);

        // 2: fill to D+2 with downstream stalled, then drain in order
        dn_rdy = 1'b0;
        push_words(12, 32'd0, 30, got);
        chk("t2_accepted", 64'(got), 64'd10);
        @(negedge clk);
        chk("t2_level", 64'(level), 64'd10);
        chk("t2_af", 64'(almost_full), 64'd1);
        chk("t2_up_rdy", 64'(up_rdy), 64'd0);
        chk("t2_head", 64'(dn_dat), 64'd0);
        drain(40);
        chk("t2_level_end", 64'(level), 64'd0);

        // 3: streaming, one word per cycle after the fill
        dn_rdy = 1'b1;
        got = 0; pops = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            up_vld = 1'b1;
            up_dat = 32'h300 + W'(got);
            @(negedge clk);
            if (up_rdy) got++;
            if (c >= 10 && dn_vld) pops++;
        end
        @(posedge clk); #1;
        up_vld = 1'b0;
        chk("t3_pushed", 64'(got), 64'd100);
        chk("t3_no_bubbles", 64'(pops), 64'd90);
        drain(20);

        // 4: random valid/ready
        got = 0;
        for (int c = 0; c < 50000 && got < 10000; c++) begin
            @(posedge clk); #1;
            up_vld = ($urandom_range(99) < 50);
            up_dat = 32'h1000_0000 + W'(got);
            dn_rdy = ($urandom_range(99) < 30);
            @(negedge clk);
            if (up_vld && up_rdy) got++;
        end
        @(posedge clk); #1;
        up_vld = 1'b0;
        chk("t4_pushed", 64'(got), 64'd10000);
        drain(40);

        // 5: flush at level 6 with a push and pop offered in the same cycle
        dn_rdy = 1'b0;
        push_words(6, 32'h500, 20, got);
        @(negedge clk);
        chk("t5_level6", 64'(level), 64'd6);
        @(posedge clk); #1;
        flush = 1'b1; up_vld = 1'b1; up_dat = 32'hDEAD; dn_rdy = 1'b1;
        @(negedge clk);
        chk("t5_up_rdy_flush", 64'(up_rdy), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; up_vld = 1'b0;
        @(negedge clk);
        chk("t5_level0", 64'(level), 64'd0);
        chk("t5_dn_vld", 64'(dn_vld), 64'd0);
        chk("t5_ae", 64'(almost_empty), 64'd1);
        push_words(1, 32'h77, 5, got);
        drain(20);

        // 6: asynchronous reset mid-burst
        dn_rdy = 1'b0;
        push_words(5, 32'h600, 20, got);
        @(negedge clk);
        chk("t6_level5", 64'(level), 64'd5);
        @(posedge clk); #1;
        up_vld = 1'b1; up_dat = 32'h666; rst_n = 1'b0;
        #1;
        chk("t6_rst_dn_vld", 64'(dn_vld), 64'd0);
        chk("t6_rst_level", 64'(level), 64'd0);
        @(posedge clk); #2;
        up_vld = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        up_vld = 1'b1; up_dat = 32'h55; dn_rdy = 1'b1;
        @(posedge clk); #1;
        up_vld = 1'b0;
        @(negedge clk);
        chk("t6_vld_e0", 64'(dn_vld), 64'd0);
        @(negedge clk);
        chk("t6_vld_e1", 64'(dn_vld), 64'd0);
        @(negedge clk);
        chk("t6_vld_e2", 64'(dn_vld), 64'd1);
        chk("t6_dat_e2", 64'(dn_dat), 64'h55);
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
